// File: rtl/uio_port_arbiter.sv
// uio_port_arbiter
//   Shares the 8-bit bidirectional uio pad group among NREQ internal
//   requesters. Grants are round-robin, each burst is limited to MAX_HOLD
//   beats, and TURN_CYCLES pad-idle cycles are inserted whenever the bus
//   direction changes so the pads are never driven against an external
//   source.
//
// Ports
//   clk, rst_n   : clock, asynchronous active-low reset
//   ena          : top-level enable; low blocks grants and aborts a burst
//   req[NREQ]    : per-requester request, held for the whole burst
//   dir[NREQ]    : 1 = write (drive pads), 0 = read; sampled at grant
//   last[NREQ]   : marks the final beat of the owner's burst
//   wdata[8*NREQ]: write data, requester i on bits [8i+7:8i]
//   gnt[NREQ]    : registered one-hot grant
//   beat         : transfer strobe while a burst is active
//   rdata        : registered capture of uio_in on read beats
//   rdata_valid  : one-cycle pulse the cycle after a read beat
//   uio_in/out/oe: pad group (uio_oe is only ever 8'h00 or 8'hFF)
module uio_port_arbiter #(
    parameter int NREQ        = 2,
    parameter int TURN_CYCLES = 1,
    parameter int MAX_HOLD    = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ena,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ-1:0]   dir,
    input  logic [NREQ-1:0]   last,
    input  logic [8*NREQ-1:0] wdata,
    output logic [NREQ-1:0]   gnt,
    output logic              beat,
    output logic [7:0]        rdata,
    output logic              rdata_valid,
    input  logic [7:0]        uio_in,
    output logic [7:0]        uio_out,
    output logic [7:0]        uio_oe
);

    localparam int OW = (NREQ > 2) ? 2 : 1;

    typedef enum logic [1:0] {IDLE, TURN, XFER} state_t;

    state_t          state, state_nx;
    logic [OW-1:0]   owner, owner_nx;
    logic [OW-1:0]   ptr, ptr_nx;
    logic [OW-1:0]   pick;
    logic            found;
    logic            cur_dir, cur_dir_nx;
    logic            last_dir, last_dir_nx;
    logic [3:0]      beat_cnt, beat_cnt_nx;
    logic [1:0]      turn_cnt, turn_cnt_nx;
    logic [NREQ-1:0] gnt_nx;
    logic [OW-1:0]   owner_inc;
    logic            rd_beat;
    logic            driving;

    // Round-robin search: first set request scanning from ptr with wrap.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            int unsigned idx;
            idx = (32'(ptr) + i) % NREQ;
            if (!found && req[idx]) begin
                found = 1'b1;
                pick  = OW'(idx);
            end
        end
    end

    assign owner_inc = (32'(owner) == 32'(NREQ - 1)) ? '0 : owner + 1'b1;

    always_comb begin
        state_nx    = state;
        owner_nx    = owner;
        ptr_nx      = ptr;
        cur_dir_nx  = cur_dir;
        last_dir_nx = last_dir;
        beat_cnt_nx = beat_cnt;
        turn_cnt_nx = turn_cnt;
        gnt_nx      = gnt;
        beat        = 1'b0;
        rd_beat     = 1'b0;
        case (state)
            IDLE: begin
                gnt_nx = '0;
                if (ena && found) begin
                    owner_nx    = pick;
                    cur_dir_nx  = dir[pick];
                    beat_cnt_nx = '0;
                    if (dir[pick] == last_dir) begin
                        state_nx = XFER;
                        gnt_nx   = NREQ'(1) << pick;
                    end else begin
                        state_nx    = TURN;
                        turn_cnt_nx = 2'(TURN_CYCLES);
                    end
                end
            end
            TURN: begin
                gnt_nx = '0;
                // An abort during turnaround never touched the pads, so the
                // bus keeps its previous direction.
                if (!ena) begin
                    state_nx = IDLE;
                end else if (turn_cnt == 2'd1) begin
                    state_nx = XFER;
                    gnt_nx   = NREQ'(1) << owner;
                end else begin
                    turn_cnt_nx = turn_cnt - 2'd1;
                end
            end
            XFER: begin
                if (!ena) begin
                    // Abort: no beat, round-robin pointer left in place.
                    state_nx    = IDLE;
                    gnt_nx      = '0;
                    last_dir_nx = cur_dir;
                end else if (!req[owner]) begin
                    state_nx    = IDLE;
                    gnt_nx      = '0;
                    last_dir_nx = cur_dir;
                    ptr_nx      = owner_inc;
                end else begin
                    beat        = gnt[owner];
                    rd_beat     = gnt[owner] & ~cur_dir;
                    beat_cnt_nx = beat_cnt + 4'd1;
                    if (last[owner] || beat_cnt_nx == 4'(MAX_HOLD)) begin
                        state_nx    = IDLE;
                        gnt_nx      = '0;
                        last_dir_nx = cur_dir;
                        ptr_nx      = owner_inc;
                    end
                end
            end
            default: begin
                state_nx = IDLE;
                gnt_nx   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            owner       <= '0;
            ptr         <= '0;
            cur_dir     <= 1'b0;
            last_dir    <= 1'b0;
            beat_cnt    <= '0;
            turn_cnt    <= '0;
            gnt         <= '0;
            rdata       <= '0;
            rdata_valid <= 1'b0;
        end else begin
            state       <= state_nx;
            owner       <= owner_nx;
            ptr         <= ptr_nx;
            cur_dir     <= cur_dir_nx;
            last_dir    <= last_dir_nx;
            beat_cnt    <= beat_cnt_nx;
            turn_cnt    <= turn_cnt_nx;
            gnt         <= gnt_nx;
            rdata_valid <= rd_beat;
            if (rd_beat) begin
                rdata <= uio_in;
            end
        end
    end

    // Pad drive is decoded from registered state so an asynchronous reset
    // releases the pads immediately.
    assign driving = (state == XFER) && cur_dir;
    assign uio_oe  = driving ? '1 : '0;
    assign uio_out = driving ? wdata[8*owner +: 8] : '0;

endmodule
